// File: rtl/config_int_add_pkg.sv
// Shared types and helpers for the configurable approximate adder pipeline.
package config_int_add_pkg;

    // Controller states: normal streaming, emptying the pipe, switching k.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2
    } apx_state_t;

    // Width of a field able to hold any k in 0..max_apx.
    function automatic int cfg_width(input int max_apx);
        return $clog2(max_apx + 1);
    endfunction

endpackage

// File: rtl/apx_operand_reg.sv
// Operand register whose low bits can be frozen to emulate clock gating.
// Bits below k use the gated-lane enable, all other bits use the normal
// enable. The clear input zeroes every bit that can ever be gated.
module apx_operand_reg
    import config_int_add_pkg::*;
#(
    parameter int W = 32,
    parameter int M = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      hi_en,
    input  logic                      lo_en,
    input  logic [cfg_width(M)-1:0]   k,
    input  logic [W-1:0]              d,
    output logic [W-1:0]              q
);

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        if (gi < M) begin : g_gateable
            logic bit_reg;
            logic gated;

            // This lane is frozen while it sits inside the current k.
            assign gated = (gi < int'(k));

            // Gateable bit: cleared on a level change, loads only when ungated.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    bit_reg <= 1'b0;
                end else if (clr) begin
                    bit_reg <= 1'b0;
                end else if (gated ? lo_en : hi_en) begin
                    bit_reg <= d[gi];
                end
            end

            assign q[gi] = bit_reg;
        end else begin : g_plain
            logic bit_reg;

            // Upper bit that is never gated: loads on every accepted operand.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    bit_reg <= 1'b0;
                end else if (hi_en) begin
                    bit_reg <= d[gi];
                end
            end

            assign q[gi] = bit_reg;
        end
    end

endmodule

// File: rtl/config_int_add_apx_pipe.sv
// Two-stage approximate integer adder with a run-time gated-LSB count.
// Stage 1 holds the operands (low k bits frozen at zero), stage 2 holds the
// wrapped sum and signed overflow. Changing k first drains the pipe so no
// in-flight pair ever sees a mix of old and new approximation levels.
module config_int_add_apx_pipe
    import config_int_add_pkg::*;
#(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int MAX_APX_BITWIDTH   = 16,
    parameter int RESET_APX_BITS     = 0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0]           a,
    input  logic [DATA_PATH_BITWIDTH-1:0]           b,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0]           c,
    output logic                                    ovf,
    input  logic                                    cfg_valid,
    output logic                                    cfg_ready,
    input  logic [cfg_width(MAX_APX_BITWIDTH)-1:0]  cfg_apx_bits,
    output logic [cfg_width(MAX_APX_BITWIDTH)-1:0]  active_apx_bits
);

    localparam int W  = DATA_PATH_BITWIDTH;
    localparam int M  = MAX_APX_BITWIDTH;
    localparam int KW = cfg_width(MAX_APX_BITWIDTH);

    localparam logic [KW-1:0] MAX_K   = KW'(M);
    localparam logic [KW-1:0] RESET_K = KW'(RESET_APX_BITS);

    apx_state_t    state_reg, state_next;
    logic [KW-1:0] pending_k_reg, pending_k_next;
    logic [KW-1:0] active_k_reg, active_k_next;
    logic [KW-1:0] cfg_clamped;

    logic          s1_valid_reg;
    logic          s2_valid_reg;
    logic [W-1:0]  c_reg;
    logic          ovf_reg;

    logic [W-1:0]  s1_a;
    logic [W-1:0]  s1_b;
    logic [W-1:0]  sum;
    logic          sum_ovf;

    logic          stall;
    logic          in_fire;
    logic          cfg_fire;
    logic          apply_clr;

    // Handshake qualification. Stage 2 only blocks when it holds an
    // unaccepted result; stage 1 always empties into stage 2 otherwise.
    assign stall     = s2_valid_reg && !out_ready;
    assign in_ready  = (state_reg == RUN) && (!s2_valid_reg || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign cfg_ready = (state_reg == RUN);
    assign cfg_fire  = cfg_valid && cfg_ready;

    // Requests above the supported maximum saturate instead of wrapping.
    assign cfg_clamped = (cfg_apx_bits > MAX_K) ? MAX_K : cfg_apx_bits;

    // Gated lanes never load; the active k selects which lanes are gated.
    // An input accepted alongside a cfg request still uses the old k.
    apx_operand_reg #(
        .W (W),
        .M (M)
    ) u_reg_a (
        .clk   (clk),
        .rst   (rst),
        .clr   (apply_clr),
        .hi_en (in_fire),
        .lo_en (1'b0),
        .k     (active_k_reg),
        .d     (a),
        .q     (s1_a)
    );

    apx_operand_reg #(
        .W (W),
        .M (M)
    ) u_reg_b (
        .clk   (clk),
        .rst   (rst),
        .clr   (apply_clr),
        .hi_en (in_fire),
        .lo_en (1'b0),
        .k     (active_k_reg),
        .d     (b),
        .q     (s1_b)
    );

    // Wrapped sum; overflow when like-signed operands give an opposite sign.
    assign sum     = s1_a + s1_b;
    assign sum_ovf = (s1_a[W-1] == s1_b[W-1]) && (sum[W-1] != s1_a[W-1]);

    // Valid flags and the result stage; everything freezes under a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            c_reg        <= '0;
            ovf_reg      <= 1'b0;
        end else if (!stall) begin
            s1_valid_reg <= in_fire;
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                c_reg   <= sum;
                ovf_reg <= sum_ovf;
            end
        end
    end

    // Controller state, requested level and applied level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= RUN;
            pending_k_reg <= RESET_K;
            active_k_reg  <= RESET_K;
        end else begin
            state_reg     <= state_next;
            pending_k_reg <= pending_k_next;
            active_k_reg  <= active_k_next;
        end
    end

    // Next-state logic: latch a request, wait for an empty pipe, then switch.
    always_comb begin
        state_next     = state_reg;
        pending_k_next = pending_k_reg;
        active_k_next  = active_k_reg;
        apply_clr      = 1'b0;
        case (state_reg)
            RUN: begin
                if (cfg_fire) begin
                    state_next     = DRAIN;
                    pending_k_next = cfg_clamped;
                end
            end
            DRAIN: begin
                if (!s1_valid_reg && !s2_valid_reg) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                active_k_next = pending_k_reg;
                apply_clr     = 1'b1;
                state_next    = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign out_valid       = s2_valid_reg;
    assign c               = c_reg;
    assign ovf             = ovf_reg;
    assign active_apx_bits = active_k_reg;

endmodule

// File: tb/tb_config_int_add_apx_pipe.sv
// Directed and randomized checks for the approximate adder pipeline against
// a queue-based arithmetic model of masked two's-complement addition.
module tb_config_int_add_apx_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;
    logic        ovf;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [4:0]  cfg_apx_bits;
    logic [4:0]  active_apx_bits;

    typedef struct {
        logic [31:0] c;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   k_model;
    int   checks;
    int   failures;
    int   n_in;

    config_int_add_apx_pipe #(
        .DATA_PATH_BITWIDTH (32),
        .MAX_APX_BITWIDTH   (16),
        .RESET_APX_BITS     (0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .a               (a),
        .b               (b),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .c               (c),
        .ovf             (ovf),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_apx_bits    (cfg_apx_bits),
        .active_apx_bits (active_apx_bits)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Model: the low k bits of each operand read as zero, sum wraps at 32 bits.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int k);
        exp_t        r;
        logic [31:0] mask;
        logic [31:0] xm;
        logic [31:0] ym;
        mask  = 32'hFFFF_FFFF << k;
        xm    = x & mask;
        ym    = y & mask;
        r.c   = xm + ym;
        r.ovf = (xm[31] == ym[31]) && (r.c[31] != xm[31]);
        return r;
    endfunction

    // One clock: observe handshakes just before the edge, then advance to the
    // following falling edge where the next inputs are driven.
    task automatic tick();
        exp_t e;
        #2;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                $display("out c=0x%08h ovf=%0b model c=0x%08h ovf=%0b", c, ovf, e.c, e.ovf);
                check("out_c", 64'(c), 64'(e.c));
                check("out_ovf", 64'(ovf), 64'(e.ovf));
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, k_model));
            n_in++;
        end
        if (cfg_valid && cfg_ready) begin
            k_model = (cfg_apx_bits > 5'd16) ? 16 : int'(cfg_apx_bits);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Level change on an empty pipe: one DRAIN cycle, one APPLY cycle.
    task automatic do_cfg(input logic [4:0] val);
        int n;
        cfg_valid    = 1'b1;
        cfg_apx_bits = val;
        tick();
        cfg_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !cfg_ready; i++) begin
            tick();
            n++;
        end
        check("cfg_back_to_run", 64'(cfg_ready), 64'd1);
        check("cfg_empty_cycles", 64'(n), 64'd2);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || !cfg_ready); i++) begin
            tick();
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_cfg_ready", 64'(cfg_ready), 64'd1);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        n_in         = 0;
        k_model      = 0;
        rst          = 1'b0;
        in_valid     = 1'b0;
        a            = '0;
        b            = '0;
        out_ready    = 1'b1;
        cfg_valid    = 1'b0;
        cfg_apx_bits = '0;

        // Reset state while rst is held low.
        repeat (3) @(negedge clk);
        check("rst_c", 64'(c), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_active", 64'(active_apx_bits), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Exact adds at k=0, including signed overflow, and the latency.
        in_valid = 1'b1;
        a = 32'h0000_FFFF;
        b = 32'h0000_0001;
        tick();
        check("lat_not_yet", 64'(out_valid), 64'd0);
        a = 32'h7FFF_FFFF;
        b = 32'h0000_0001;
        tick();
        in_valid = 1'b0;
        check("lat_valid", 64'(out_valid), 64'd1);
        check("exact_c0", 64'(c), 64'h0001_0000);
        check("exact_ovf0", 64'(ovf), 64'd0);
        tick();
        check("exact_c1", 64'(c), 64'h8000_0000);
        check("exact_ovf1", 64'(ovf), 64'd1);
        drain();

        // Approximate add at k=8, then a saturating request.
        do_cfg(5'd8);
        check("active_8", 64'(active_apx_bits), 64'd8);
        in_valid = 1'b1;
        a = 32'h0000_01FF;
        b = 32'h0000_00FF;
        tick();
        in_valid = 1'b0;
        tick();
        check("apx_valid", 64'(out_valid), 64'd1);
        check("apx_c", 64'(c), 64'h0000_0100);
        drain();
        do_cfg(5'd20);
        check("active_sat", 64'(active_apx_bits), 64'd16);

        // Config issued on the second of four streamed pairs.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = $urandom;
        b = $urandom;
        tick();
        a = $urandom;
        b = $urandom;
        cfg_valid    = 1'b1;
        cfg_apx_bits = 5'd4;
        tick();
        cfg_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        for (int i = 0; i < 3; i++) begin
            check("drain_in_ready", 64'(in_ready), 64'd0);
            check("drain_active_old", 64'(active_apx_bits), 64'd16);
            tick();
        end
        check("apply_in_ready", 64'(in_ready), 64'd0);
        check("apply_active_old", 64'(active_apx_bits), 64'd16);
        tick();
        check("active_new", 64'(active_apx_bits), 64'd4);
        check("run_in_ready", 64'(in_ready), 64'd1);
        tick();
        a = $urandom;
        b = $urandom;
        tick();
        drain();

        // Backpressure: out_ready low for five cycles with three pairs offered.
        n_in      = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (n_in < 3 && i > 0 && in_valid == 1'b0) begin
                in_valid = 1'b1;
            end
            if (i < 2) begin
                a = $urandom;
                b = $urandom;
            end else if (i == 2) begin
                a = $urandom;
                b = $urandom;
            end
            if (i >= 2) begin
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_c_hold", 64'(c), 64'(exp_q[0].c));
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && n_in < 3; i++) begin
            tick();
        end
        check("bp_all_accepted", 64'(n_in), 64'd3);
        drain();

        // Randomized traffic with random stalls and level changes.
        for (int i = 0; i < 150; i++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            a            = ($urandom_range(0, 3) == 0) ? (32'h7FFF_0000 | $urandom_range(0, 65535)) : $urandom;
            b            = $urandom;
            out_ready    = ($urandom_range(0, 3) != 0);
            cfg_valid    = ($urandom_range(0, 19) == 0);
            cfg_apx_bits = 5'($urandom_range(0, 31));
            tick();
        end
        drain();

        // Reset while draining abandons the request and in-flight data.
        do_cfg(5'd0);
        in_valid = 1'b1;
        a = $urandom;
        b = $urandom;
        tick();
        in_valid     = 1'b0;
        cfg_valid    = 1'b1;
        cfg_apx_bits = 5'd12;
        tick();
        cfg_valid = 1'b0;
        check("pre_rst_draining", 64'(cfg_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_active", 64'(active_apx_bits), 64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        k_model = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h0000_0003;
        b = 32'h0000_0005;
        tick();
        in_valid = 1'b0;
        tick();
        check("post_rst_c", 64'(c), 64'h0000_0008);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
